// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider, one bit per cycle, with a
// START/BUSY/DONE handshake and a KILL input for pipeline flushes.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies are computed in a
// single cycle straight out of IDLE; divides keep the iterative path.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             KILL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           op_sel;
    logic [WIDTH-1:0]     op_a;     // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]     op_b;     // multiplier (shifted right), or divisor
    logic [2*WIDTH-1:0]   acc;      // product; low half doubles as the remainder
    logic                 sign_a;
    logic                 sign_b;
    logic [CNT_W-1:0]     cnt;

    // operand decode at request time
    logic                 a_signed;
    logic                 b_signed;
    logic                 start_sign_a;
    logic                 start_sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 div_zero;
    logic                 div_ovf;

    // per-iteration datapath
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic                 div_qbit;
    logic [WIDTH-1:0]     div_rem_next;

    // sign correction
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_result;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0]   fast_full;
    logic [2*WIDTH-1:0]   fast_prod;
    logic [WIDTH-1:0]     fast_result;
`endif

    // Signedness per funct3 and operand magnitudes. MUL is treated as unsigned:
    // its low half does not depend on operand signedness.
    always_comb begin
        a_signed     = (SELECT == 3'b001) || (SELECT == 3'b010) ||
                       (SELECT == 3'b100) || (SELECT == 3'b110);
        b_signed     = (SELECT == 3'b001) || (SELECT == 3'b100) || (SELECT == 3'b110);
        start_sign_a = a_signed && DATA1[WIDTH-1];
        start_sign_b = b_signed && DATA2[WIDTH-1];
        mag_a        = start_sign_a ? (~DATA1 + 1'b1) : DATA1;
        mag_b        = start_sign_b ? (~DATA2 + 1'b1) : DATA2;
        div_zero     = SELECT[2] && (DATA2 == '0);
        div_ovf      = SELECT[2] && !SELECT[0] &&
                       (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
    end

    // One multiply step (add-then-shift) and one restoring divide step.
    always_comb begin
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (op_b[0] ? op_a : {WIDTH{1'b0}})};
        mul_acc_next = {mul_sum, acc[WIDTH-1:1]};
        rem_sh       = {acc[WIDTH-1:0], op_a[WIDTH-1]};
        trial        = rem_sh - {1'b0, op_b};
        div_qbit     = !trial[WIDTH];
        div_rem_next = div_qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    // Final sign correction and half selection.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        quot_fix = (sign_a ^ sign_b) ? (~op_a + 1'b1) : op_a;
        rem_fix  = sign_a ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        if (op_sel[2])
            fix_result = op_sel[1] ? rem_fix : quot_fix;
        else if (op_sel[1:0] == 2'b00)
            fix_result = prod_fix[WIDTH-1:0];
        else
            fix_result = prod_fix[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle product of the request operands.
    always_comb begin
        fast_full   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_prod   = (start_sign_a ^ start_sign_b) ? (~fast_full + 1'b1) : fast_full;
        fast_result = (SELECT[1:0] == 2'b00) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
    end
`endif

    // Control FSM with registered BUSY/DONE/RESULT.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= ST_IDLE;
            op_sel <= '0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        op_sel <= SELECT;
                        op_a   <= mag_a;
                        op_b   <= mag_b;
                        sign_a <= start_sign_a;
                        sign_b <= start_sign_b;
                        acc    <= '0;
                        if (div_zero) begin
                            RESULT <= SELECT[1] ? DATA1 : {WIDTH{1'b1}};
                            DONE   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (div_ovf) begin
                            RESULT <= SELECT[1] ? {WIDTH{1'b0}} : DATA1;
                            DONE   <= 1'b1;
                            state  <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!SELECT[2]) begin
                            RESULT <= fast_result;
                            DONE   <= 1'b1;
                            state  <= ST_DONE;
                        end
`endif
                        else begin
                            cnt   <= CNT_W'(WIDTH);
                            BUSY  <= 1'b1;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (KILL) begin
                        BUSY  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        if (op_sel[2]) begin
                            acc[WIDTH-1:0] <= div_rem_next;
                            op_a           <= {op_a[WIDTH-2:0], div_qbit};
                        end else begin
                            acc  <= mul_acc_next;
                            op_b <= {1'b0, op_b[WIDTH-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    BUSY <= 1'b0;
                    if (KILL) begin
                        state <= ST_IDLE;
                    end else begin
                        RESULT <= fix_result;
                        DONE   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): vector table plus handshake,
// KILL, START-while-busy and asynchronous reset sequences.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          START = 1'b0;
    logic [2:0]    SELECT = 3'b000;
    logic [W-1:0]  DATA1 = '0;
    logic [W-1:0]  DATA2 = '0;
    logic          KILL = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic [W-1:0]  RESULT;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request and wait for DONE; returns result and latency in edges.
    task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output logic busy_ok);
        logic got;
        @(negedge CLK);
        SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        lat = 1; busy_ok = 1'b1; got = 1'b0; res = '0;
        while (!got && lat < 200) begin
            @(negedge CLK);
            if (DONE) begin
                got = 1'b1;
                res = RESULT;
                if (BUSY) busy_ok = 1'b0;
            end else begin
                if (!BUSY) busy_ok = 1'b0;
                @(posedge CLK);
                lat++;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [W-1:0] res;
        int           lat;
        logic         bok;
        issue(v.sel, v.a, v.b, res, lat, bok);
        chk({v.name, " result"}, res, v.exp);
        chk({v.name, " latency"}, W'(lat), W'(v.lat));
        chk({v.name, " busy"}, {31'b0, bok}, 32'd1);
        @(negedge CLK);
        chk({v.name, " done pulse"}, {31'b0, DONE}, 32'd0);
        chk({v.name, " result hold"}, RESULT, v.exp);
    endtask

    int           dcount;
    logic [W-1:0] res;
    int           lat;
    logic         bok;

    initial begin
        vecs[0]  = '{"mul 5*2",        3'b000, 32'd5,        32'd2,        32'd10,       MUL_LAT};
        vecs[1]  = '{"mul -3*7",       3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, MUL_LAT};
        vecs[2]  = '{"div 10/2",       3'b100, 32'd10,       32'd2,        32'd5,        DIV_LAT};
        vecs[3]  = '{"rem 27,5",       3'b110, 32'd27,       32'd5,        32'd2,        DIV_LAT};
        vecs[4]  = '{"div -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT};
        vecs[5]  = '{"rem -7,2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT};
        vecs[6]  = '{"divu fffffffe/2",3'b101, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, DIV_LAT};
        vecs[7]  = '{"div 7/-2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
        vecs[8]  = '{"rem 7,-2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT};
        vecs[9]  = '{"remu 100,7",     3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT};
        vecs[10] = '{"mulh min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
        vecs[11] = '{"mulhu max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[12] = '{"mulhsu -1,2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT};
        vecs[13] = '{"div 10/0",       3'b100, 32'd10,       32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{"remu 10/0",      3'b111, 32'd10,       32'd0,        32'd10,       1};
        vecs[15] = '{"div ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[16] = '{"rem ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[17] = '{"divu 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT};

        // reset state
        #12;
        chk("reset busy", {31'b0, BUSY}, 32'd0);
        chk("reset done", {31'b0, DONE}, 32'd0);
        chk("reset result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // KILL at cycle 10 of DIV 100/7: no DONE, RESULT keeps 14
        @(negedge CLK);
        SELECT = 3'b100; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        KILL = 1'b1;
        @(posedge CLK);
        #1 KILL = 1'b0;
        @(negedge CLK);
        chk("kill busy", {31'b0, BUSY}, 32'd0);
        chk("kill done", {31'b0, DONE}, 32'd0);
        chk("kill result", RESULT, 32'd14);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) dcount++;
        end
        chk("kill no done", dcount, 0);
        issue(3'b000, 32'd3, 32'd4, res, lat, bok);
        chk("mul 3*4 after kill", res, 32'd12);
        chk("mul 3*4 latency", W'(lat), W'(MUL_LAT));

        // START pulsed at cycle 5 of a busy DIV 100/7 is ignored
        @(negedge CLK);
        SELECT = 3'b100; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        SELECT = 3'b000; DATA1 = 32'd50; DATA2 = 32'd3; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        dcount = 0; lat = 6; res = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (DONE) begin
                if (dcount == 0) begin res = RESULT; lat = 6 + i; end
                dcount++;
            end
        end
        chk("busy start result", res, 32'd14);
        chk("busy start done count", dcount, 1);
        chk("busy start latency", W'(lat), W'(DIV_LAT));

        // START held through the DONE cycle is ignored; KILL with START in IDLE loses
        @(negedge CLK);
        SELECT = 3'b100; DATA1 = 32'd10; DATA2 = 32'd0; START = 1'b1; KILL = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("start+kill done", {31'b0, DONE}, 32'd1);
        chk("start+kill result", RESULT, 32'hFFFFFFFF);
        @(posedge CLK);
        @(negedge CLK);
        chk("done-cycle start done", {31'b0, DONE}, 32'd0);
        chk("done-cycle start busy", {31'b0, BUSY}, 32'd0);
        START = 1'b0; KILL = 1'b0;

        // asynchronous reset mid-CALC
        issue(3'b101, 32'd100, 32'd7, res, lat, bok);
        chk("pre-reset result", res, 32'd14);
        @(negedge CLK);
        SELECT = 3'b100; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (8) @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        chk("async reset busy", {31'b0, BUSY}, 32'd0);
        chk("async reset done", {31'b0, DONE}, 32'd0);
        chk("async reset result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        issue(3'b110, 32'd27, 32'd5, res, lat, bok);
        chk("post-reset rem", res, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
